mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised MEM stage plus MEM/WB pipeline register for the pipelined ARM core.
//  Holds the on-chip data memory, with word/byte store and load and an optional +1 store-data adjust.
//  Registers the MEM results into WB with stall, flush and valid tracking.
//  Drives the WB result mux (ResultW) to the register file.
// PARAMETERS
//  DATA_W  32  datapath / memory word width in bits (multiple of 8)
//  ADDR_W  6   word-address bits; memory holds 2**ADDR_W words
//  REG_W   4   register-file index width (WA3)
// PORTS
//  clock       in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  ValidM      in   1       a real instruction occupies MEM this cycle
//  ALUResultM  in   DATA_W  byte address / ALU result from EX
//  WriteDataM  in   DATA_W  store data
//  WA3M        in   REG_W   destination register
//  MemWriteM   in   1       store
//  MemToRegM   in   1       load: WB takes memory data
//  RegWriteM   in   1       instruction writes the register file
//  PlusOneM    in   1       store WriteDataM+1 instead of WriteDataM
//  ByteM       in   1       byte access (0 = word)
//  StallW      in   1       hold the WB register
//  FlushW      in   1       kill the instruction moving MEM->WB
//  ValidW      out  1       WB holds a valid instruction
//  RegWriteW   out  1       registered write enable (ValidM & RegWriteM)
//  MemToRegW   out  1       registered MemToRegM
//  ReadDataW   out  DATA_W  registered load data
//  ALUOutW     out  DATA_W  registered ALUResultM
//  WA3W        out  REG_W   registered WA3M
//  AddrFaultW  out  1       registered out-of-range flag for a load or store
//  ResultW     out  DATA_W  MemToRegW ? ReadDataW : ALUOutW (combinational)
// BEHAVIOUR
//  Addressing:
//   - Word index = ALUResultM[ADDR_W+1:2]; byte lane = ALUResultM[1:0].
//   - Word accesses ignore bits [1:0].
//   - fault = any ALUResultM bit above ADDR_W+1 set, AND (MemWriteM | MemToRegM).
//  Store data:
//   - sd = PlusOneM ? WriteDataM+1 : WriteDataM; DATA_W-bit, wraps mod 2**DATA_W.
//  Write:
//   - Commits at the rising edge when ValidM & MemWriteM & !fault & !StallW & !FlushW & reset_n.
//   - ByteM=1: only lane ALUResultM[1:0] is written, with sd[7:0]. Other bytes are unchanged.
//   - ByteM=0: the full word is written with sd.
//   - Suppressed store: memory is unchanged.
//  Read:
//   - Combinational, same cycle as MEM.
//   - Same-cycle read/write to one word returns the pre-write data.
//   - ByteM=1: the selected lane, zero-extended to DATA_W.
//   - fault: read data forced to 0.
//  Memory contents are not reset; they are undefined until written.
//  WB register, priority reset > flush > stall > load:
//   - reset_n low (async): every registered output is 0, so ResultW is 0.
//   - FlushW: ValidW, RegWriteW, MemToRegW, AddrFaultW <= 0; data fields <= 0. Store is suppressed.
//   - StallW: all WB fields hold; the store is not committed this cycle.
//     It commits when the instruction is re-presented without stall.
//   - Otherwise: ValidW<=ValidM, RegWriteW<=ValidM&RegWriteM, MemToRegW<=ValidM&MemToRegM,
//     AddrFaultW<=ValidM&fault; ReadDataW, ALUOutW, WA3W are captured.
//  Latency: MEM inputs appear on the W outputs 1 cycle later; ResultW is valid in that same cycle.
//  Reset asserted mid-store: write suppressed, W outputs clear immediately (asynchronous).
//  ValidM=0: no store; W loads a bubble (ValidW=0, RegWriteW=0).
// TESTING
//  - Reset: hold reset_n=0 with random inputs -> every W output and ResultW = 0. No memory write.
//  - Word store 0x12345678 @0x10, then word load @0x10 with MemToRegM=1 -> next cycle
//    ReadDataW=0x12345678, ResultW=0x12345678.
//  - PlusOneM=1: store 0xFFFFFFFF @0x4 -> reads 0x00000000. Store 0x41 @0x8 -> reads 0x42.
//  - Word 0xAABBCCDD @0x20; byte store 0x11 @0x22 -> word reads 0xAA11CCDD;
//    byte load @0x23 -> 0x000000AA.
//  - StallW=1 during store 0x5 @0x30 -> memory unchanged, W outputs hold.
//    FlushW=1 and StallW=1 together -> ValidW=0, store dropped.
//  - ADDR_W=6, store/load @0x100 -> no write, AddrFaultW=1, ReadDataW=0.
//    ALU-only op @0x100 -> AddrFaultW=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage with on-chip data memory (word/byte access, optional +1 store adjust)
// followed by the MEM/WB pipeline register and the WB result mux.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ValidM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WA3M,
    input  logic              MemWriteM,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic              PlusOneM,
    input  logic              ByteM,
    input  logic              StallW,
    input  logic              FlushW,
    output logic              ValidW,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WA3W,
    output logic              AddrFaultW,
    output logic [DATA_W-1:0] ResultW
);

    localparam int unsigned Words = 2 ** ADDR_W;
    localparam int unsigned ShW   = $clog2(DATA_W);

    logic [DATA_W-1:0] mem [Words];

    logic [ADDR_W-1:0] word_idx;
    logic [ShW-1:0]    lane_sh;
    logic              fault;
    logic [DATA_W-1:0] sd;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_word;
    logic              mem_we;

    logic              valid_q;
    logic              regwrite_q;
    logic              memtoreg_q;
    logic              fault_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] aluout_q;
    logic [REG_W-1:0]  wa3_q;

    assign word_idx = ALUResultM[ADDR_W+1:2];
    assign lane_sh  = ShW'({ALUResultM[1:0], 3'b000});
    assign fault    = (|ALUResultM[DATA_W-1:ADDR_W+2]) & (MemWriteM | MemToRegM);
    assign sd       = PlusOneM ? WriteDataM + DATA_W'(1) : WriteDataM;
    assign mem_we   = ValidM & MemWriteM & ~fault & ~StallW & ~FlushW;

    assign rd_raw = mem[word_idx];

    always_comb begin
        rd_data = '0;
        if (!fault) begin
            rd_data = ByteM ? DATA_W'(rd_raw[lane_sh +: 8]) : rd_raw;
        end
    end

    // Byte stores are done as read-modify-write of the whole word.
    always_comb begin
        wr_word = sd;
        if (ByteM) begin
            wr_word = rd_raw;
            wr_word[lane_sh +: 8] = sd[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
            aluout_q   <= '0;
            wa3_q      <= '0;
        end else if (FlushW) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
            aluout_q   <= '0;
            wa3_q      <= '0;
        end else if (!StallW) begin
            valid_q    <= ValidM;
            regwrite_q <= ValidM & RegWriteM;
            memtoreg_q <= ValidM & MemToRegM;
            fault_q    <= ValidM & fault;
            rdata_q    <= rd_data;
            aluout_q   <= ALUResultM;
            wa3_q      <= WA3M;
        end
    end

    assign ValidW     = valid_q;
    assign RegWriteW  = regwrite_q;
    assign MemToRegW  = memtoreg_q;
    assign AddrFaultW = fault_q;
    assign ReadDataW  = rdata_q;
    assign ALUOutW    = aluout_q;
    assign WA3W       = wa3_q;
    assign ResultW    = memtoreg_q ? rdata_q : aluout_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus random traffic checked
// against a byte-addressed memory model and an expected WB register image.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int RW = 4;
    localparam int MemBytes = 4 * (2 ** AW);

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          ValidM, MemWriteM, MemToRegM, RegWriteM, PlusOneM, ByteM, StallW, FlushW;
    logic [DW-1:0] ALUResultM, WriteDataM;
    logic [RW-1:0] WA3M;
    logic          ValidW, RegWriteW, MemToRegW, AddrFaultW;
    logic [DW-1:0] ReadDataW, ALUOutW, ResultW;
    logic [RW-1:0] WA3W;

    always #5 clock = ~clock;

    mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ValidM     (ValidM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .WA3M       (WA3M),
        .MemWriteM  (MemWriteM),
        .MemToRegM  (MemToRegM),
        .RegWriteM  (RegWriteM),
        .PlusOneM   (PlusOneM),
        .ByteM      (ByteM),
        .StallW     (StallW),
        .FlushW     (FlushW),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .MemToRegW  (MemToRegW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .WA3W       (WA3W),
        .AddrFaultW (AddrFaultW),
        .ResultW    (ResultW)
    );

    int errors = 0;
    int checks = 0;

    // Reference memory: one byte per address, with a "has been written" flag.
    logic [7:0] mem_b [MemBytes];
    bit         known_b [MemBytes];

    // Expected WB register image.
    logic          e_valid, e_rw, e_mtr, e_fault;
    logic [DW-1:0] e_rd, e_alu;
    logic [RW-1:0] e_wa3;
    bit            e_rd_known;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        e_valid = 0; e_rw = 0; e_mtr = 0; e_fault = 0;
        e_rd = '0; e_alu = '0; e_wa3 = '0; e_rd_known = 1;
    endtask

    task automatic compare_w();
        check("ValidW", DW'(ValidW), DW'(e_valid));
        check("RegWriteW", DW'(RegWriteW), DW'(e_rw));
        check("MemToRegW", DW'(MemToRegW), DW'(e_mtr));
        check("AddrFaultW", DW'(AddrFaultW), DW'(e_fault));
        check("ALUOutW", ALUOutW, e_alu);
        check("WA3W", DW'(WA3W), DW'(e_wa3));
        if (e_rd_known) check("ReadDataW", ReadDataW, e_rd);
        if (!e_mtr) check("ResultW", ResultW, e_alu);
        else if (e_rd_known) check("ResultW", ResultW, e_rd);
    endtask

    // One clock: predict from pre-edge inputs, clock, update model, compare.
    task automatic step();
        logic          f, wr;
        logic [DW-1:0] a, rd, sd;
        bit            rdk;
        int            base;
        a    = ALUResultM;
        f    = (a >= MemBytes) && (MemWriteM || MemToRegM);
        base = int'(a[7:0]) & 'hFC;
        if (f) begin
            rd = '0; rdk = 1;
        end else if (ByteM) begin
            rd = {24'h0, mem_b[a[7:0]]}; rdk = known_b[a[7:0]];
        end else begin
            rd  = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
            rdk = known_b[base] && known_b[base+1] && known_b[base+2] && known_b[base+3];
        end
        sd = PlusOneM ? WriteDataM + 1 : WriteDataM;
        wr = reset_n && ValidM && MemWriteM && !f && !StallW && !FlushW;
        @(posedge clock);
        #1;
        if (wr) begin
            if (ByteM) begin
                mem_b[a[7:0]] = sd[7:0]; known_b[a[7:0]] = 1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    mem_b[base+i] = sd[8*i +: 8]; known_b[base+i] = 1;
                end
            end
        end
        if (!reset_n || FlushW) begin
            clear_exp();
        end else if (!StallW) begin
            e_valid = ValidM;
            e_rw    = ValidM && RegWriteM;
            e_mtr   = ValidM && MemToRegM;
            e_fault = ValidM && f;
            e_rd    = rd;
            e_rd_known = rdk;
            e_alu   = a;
            e_wa3   = WA3M;
        end
        compare_w();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         input logic [RW-1:0] wa, input logic mw, input logic mtr,
                         input logic rw, input logic p1, input logic by,
                         input logic st, input logic fl);
        ValidM = v; ALUResultM = a; WriteDataM = wd; WA3M = wa; MemWriteM = mw;
        MemToRegM = mtr; RegWriteM = rw; PlusOneM = p1; ByteM = by; StallW = st; FlushW = fl;
    endtask

    task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic p1,
                         input logic by);
        drive(1, a, d, 0, 1, 0, 0, p1, by, 0, 0);
        step();
    endtask

    task automatic load(input logic [DW-1:0] a, input logic by);
        drive(1, a, 32'h0, 4'd7, 0, 1, 1, 0, by, 0, 0);
        step();
    endtask

    task automatic drive_random();
        logic [DW-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? 32'h100 + $urandom_range(0, 255)
                                        : DW'($urandom_range(0, MemBytes - 1));
        drive($urandom_range(0, 7) != 0, a, $urandom, 4'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    endtask

    initial begin
        clear_exp();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 compare_w();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            step();
        end
        reset_n = 1'b1;

        store(32'h10, 32'h12345678, 0, 0);
        load(32'h10, 0);
        check("ld_word_0x10", ReadDataW, 32'h12345678);
        check("res_word_0x10", ResultW, 32'h12345678);

        store(32'h4, 32'hFFFFFFFF, 1, 0);
        load(32'h4, 0);
        check("plus1_wrap", ReadDataW, 32'h0);
        store(32'h8, 32'h41, 1, 0);
        load(32'h8, 0);
        check("plus1_0x41", ResultW, 32'h42);

        store(32'h20, 32'hAABBCCDD, 0, 0);
        store(32'h22, 32'h11, 0, 1);
        load(32'h20, 0);
        check("byte_merge", ReadDataW, 32'hAA11CCDD);
        load(32'h23, 1);
        check("byte_load", ReadDataW, 32'h000000AA);

        store(32'h30, 32'h77, 0, 0);
        drive(1, 32'h1234, 0, 4'd5, 0, 0, 1, 0, 0, 0, 0);
        step();
        drive(1, 32'h30, 32'h5, 4'd2, 1, 0, 0, 0, 0, 1, 0);
        step();
        check("stall_hold_alu", ALUOutW, 32'h1234);
        check("stall_hold_wa3", DW'(WA3W), 32'd5);
        load(32'h30, 0);
        check("stall_no_store", ReadDataW, 32'h77);
        drive(1, 32'h30, 32'h9, 4'd2, 1, 0, 1, 0, 0, 1, 1);
        step();
        check("flush_stall_valid", DW'(ValidW), 32'd0);
        load(32'h30, 0);
        check("flush_no_store", ReadDataW, 32'h77);

        store(32'h0, 32'h13579BDF, 0, 0);
        store(32'h100, 32'h55, 0, 0);
        check("fault_store_flag", DW'(AddrFaultW), 32'd1);
        load(32'h100, 0);
        check("fault_load_flag", DW'(AddrFaultW), 32'd1);
        check("fault_load_data", ReadDataW, 32'h0);
        load(32'h0, 0);
        check("fault_no_write", ReadDataW, 32'h13579BDF);
        drive(1, 32'h100, 0, 4'd1, 0, 0, 1, 0, 0, 0, 0);
        step();
        check("alu_no_fault", DW'(AddrFaultW), 32'd0);

        // Asynchronous reset landing in the middle of a store cycle.
        store(32'h3C, 32'hCAFEF00D, 0, 0);
        drive(1, 32'h3C, 32'h0BADBEEF, 4'd3, 1, 0, 1, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", DW'(ValidW), 32'd0);
        check("async_result", ResultW, 32'h0);
        clear_exp();
        step();
        reset_n = 1'b1;
        load(32'h3C, 0);
        check("reset_no_store", ReadDataW, 32'hCAFEF00D);

        for (int i = 0; i < 400; i++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
